serial_sum_collector: RTL and testbench

//  Downstream stage of serial_adder: shifts in the LSB-first sum bit stream (s)
//  and the final carry (cout), then presents one parallel WIDTH-bit result plus

---
 rtl/serial_pkg.sv | 17 +
 rtl/sipo_bit_slot.sv | 22 ++
 rtl/serial_sum_collector.sv | 126 ++++++++++++
 tb/tb_serial_sum_collector.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial adder datapath: collector FSM encoding,
// default word width and the bit-counter width helper.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/sipo_bit_slot.sv
// Indexed-write register: one bit is written in place per enabled cycle.
module sipo_bit_slot #(
    parameter int WIDTH = 4,
    parameter int IW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic             wr_bit,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (wr_en) begin
            q[wr_idx] <= wr_bit;
        end
    end

endmodule

// File: rtl/serial_sum_collector.sv
// Collects an LSB-first serial sum plus final carry into one parallel word
// behind a valid/ready handshake. SERIAL_COLLECT_SAT_EN enables saturation on carry.
module serial_sum_collector
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_in,
    input  logic             cout_in,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             drop
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   wr_idx;
    logic            wr_en;
    logic            restart;
    logic            last;
    logic            drop_nxt;
    logic [WIDTH-1:0] slot_q;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_idx    = cnt;
        restart   = 1'b0;
        last      = 1'b0;
        drop_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    wr_en     = 1'b1;
                    wr_idx    = '0;
                    restart   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                wr_en = 1'b1;
                // A new start abandons the partial word without signalling drop.
                if (start) begin
                    wr_idx  = '0;
                    restart = 1'b1;
                end else if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        wr_en     = 1'b1;
                        wr_idx    = '0;
                        restart   = 1'b1;
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (start) begin
                    drop_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            out_carry <= 1'b0;
            drop      <= 1'b0;
        end else begin
            drop <= drop_nxt;
            if (restart) begin
                cnt <= CW'(1);
            end else if (last) begin
                cnt       <= '0;
                out_carry <= cout_in;
            end else if (state == SHIFT) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    sipo_bit_slot #(.WIDTH(WIDTH), .IW(CW)) u_slot (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_idx (wr_idx),
        .wr_bit (s_in),
        .q      (slot_q)
    );

`ifdef SERIAL_COLLECT_SAT_EN
    logic sat;

    always_ff @(posedge clk) begin
        if (!rst)      sat <= 1'b0;
        else if (last) sat <= cout_in;
    end

    assign out_sum = sat ? '1 : slot_q;
`else
    assign out_sum = slot_q;
`endif

    assign out_valid = (state == HOLD);
    assign busy      = (state == SHIFT);

endmodule

// File: tb/tb_serial_sum_collector.sv
// Scoreboard bench for serial_sum_collector: a bit-serial adder model drives
// the stream and queues the expected word; accepted outputs are popped and compared.
module tb_serial_sum_collector;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             s_in = 1'b0;
    logic             cout_in = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             busy;
    logic             drop;

    int n_vec = 0;
    int n_err = 0;
    logic [WIDTH:0] sb[$];

    serial_sum_collector #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_in      (s_in),
        .cout_in   (cout_in),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one word LSB first through a serial adder model; queue its result.
    task automatic send_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic c;
        logic [WIDTH-1:0] s;
        c = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]    = a[i] ^ b[i] ^ c;
            c       = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
            start   = (i == 0);
            s_in    = s[i];
            cout_in = c;
            if (i == 0) begin
`ifdef SERIAL_COLLECT_SAT_EN
                logic [WIDTH-1:0] ones;
                ones = '1;
                sb.push_back({c_final(a, b), c_final(a, b) ? ones : a + b});
`else
                sb.push_back({c_final(a, b), WIDTH'(a + b)});
`endif
            end
            tick();
        end
        start = 1'b0;
    endtask

    function automatic logic c_final(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] t;
        t = {1'b0, a} + {1'b0, b};
        return t[WIDTH];
    endfunction

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                logic [WIDTH:0] e;
                e = sb.pop_front();
                chk("sum", 32'(out_sum), 32'(e[WIDTH-1:0]));
                chk("carry", 32'(out_carry), 32'(e[WIDTH]));
            end
        end
    end

    initial begin
        // reset
        rst = 1'b0;
        tick();
        tick();
        chk("rst_sum", 32'(out_sum), 0);
        chk("rst_carry", 32'(out_carry), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_drop", 32'(drop), 0);
        rst = 1'b1;
        tick();

        // basic word, valid for exactly one cycle
        out_ready = 1'b1;
        send_word(4'b0110, 4'b0011);
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_busy", 32'(busy), 0);
        tick();
        chk("t2_valid_drop", 32'(out_valid), 0);

        // carry out of the top bit
        send_word(4'b1111, 4'b0001);
        chk("t3_valid", 32'(out_valid), 1);
        tick();

        // back-pressure with an ignored start
        out_ready = 1'b0;
        send_word(4'b0110, 4'b0011);
        chk("t4_valid0", 32'(out_valid), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_drop", 32'(drop), 1);
        chk("t4_valid1", 32'(out_valid), 1);
        chk("t4_sum_held", 32'(out_sum), 32'h9);
        tick();
        chk("t4_drop_clr", 32'(drop), 0);
        chk("t4_valid2", 32'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        chk("t4_valid_drop", 32'(out_valid), 0);

        // back-to-back words
        send_word(4'b0110, 4'b0011);
        chk("t5_valid_a", 32'(out_valid), 1);
        send_word(4'b0010, 4'b0011);
        chk("t5_drop", 32'(drop), 0);
        chk("t5_valid_b", 32'(out_valid), 1);
        tick();
        chk("t5_idle", 32'(out_valid), 0);

        // restart mid-word: only the second word counts
        start = 1'b1; s_in = 1'b1; tick();
        start = 1'b0; s_in = 1'b1; tick();
        chk("restart_busy", 32'(busy), 1);
        send_word(4'b0101, 4'b0110);
        chk("restart_valid", 32'(out_valid), 1);
        tick();

        // reset at bit 2 of a word
        start = 1'b1; s_in = 1'b1; tick();
        start = 1'b0; s_in = 1'b1; tick();
        rst = 1'b0;
        tick();
        chk("t6_sum", 32'(out_sum), 0);
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_carry", 32'(out_carry), 0);
        rst = 1'b1;
        tick();
        send_word(4'b1000, 4'b1001);
        chk("t6_valid_after", 32'(out_valid), 1);
        tick();

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("sb_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
